// File: rtl/branch_resolve_if.sv
// branch_resolve_if: EX-stage resolver bundle.
// Carries ID/EX inputs, flush/rollback and predictor feedback.
interface branch_resolve_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 valid_ex;
  logic                 PL_stall;
  logic                 B_type_ex;
  logic [2:0]           func3_ex;
  logic                 jalr_pred_ex;
  logic [31:0]          pc_ex;
  logic [31:0]          imme_ex;
  logic [31:0]          rs1_data_ex;
  logic [31:0]          rs2_data_ex;
  logic                 B_type_prediction_result_ex;
  logic [31:0]          jalr_pc_prediction_ex;
  logic                 PL_flush;
  logic [31:0]          pc_rollback;
  logic                 B_type_branch_failed;
  logic                 beq_branch_failed;
  logic                 bne_branch_failed;
  logic                 blt_branch_failed;
  logic                 bge_branch_failed;
  logic                 bltu_branch_failed;
  logic                 bgeu_branch_failed;
  logic [31:0]          pc_branch_filled;
  logic                 B_type_prediction_result_branch_failed;
  logic [CNT_WIDTH-1:0] branch_cnt;
  logic [CNT_WIDTH-1:0] miss_cnt;

  modport master (
    output valid_ex, PL_stall, B_type_ex, func3_ex,
    output jalr_pred_ex, pc_ex, imme_ex,
    output rs1_data_ex, rs2_data_ex,
    output B_type_prediction_result_ex,
    output jalr_pc_prediction_ex,
    input  PL_flush, pc_rollback,
    input  B_type_branch_failed,
    input  beq_branch_failed, bne_branch_failed,
    input  blt_branch_failed, bge_branch_failed,
    input  bltu_branch_failed, bgeu_branch_failed,
    input  pc_branch_filled,
    input  B_type_prediction_result_branch_failed,
    input  branch_cnt, miss_cnt
  );

  modport slave (
    input  valid_ex, PL_stall, B_type_ex, func3_ex,
    input  jalr_pred_ex, pc_ex, imme_ex,
    input  rs1_data_ex, rs2_data_ex,
    input  B_type_prediction_result_ex,
    input  jalr_pc_prediction_ex,
    output PL_flush, pc_rollback,
    output B_type_branch_failed,
    output beq_branch_failed, bne_branch_failed,
    output blt_branch_failed, bge_branch_failed,
    output bltu_branch_failed, bgeu_branch_failed,
    output pc_branch_filled,
    output B_type_prediction_result_branch_failed,
    output branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: resolves B-type and predicted jalr in EX.
// Registers a one-cycle flush plus predictor training strobes.
module branch_resolve #(
  parameter int CNT_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 flush_q;
  logic [31:0]          rollback_q;
  logic [31:0]          filled_q;
  logic                 bfail_q;
  logic [5:0]           fail_q;
  logic                 pred_q;
  logic [CNT_WIDTH-1:0] bcnt_q;
  logic [CNT_WIDTH-1:0] mcnt_q;

  logic        eval;
  logic        b_eval;
  logic        j_eval;
  logic [5:0]  cond;
  logic        eq;
  logic        lt;
  logic        ltu;
  logic        taken;
  logic        b_miss;
  logic        j_miss;
  logic        miss;
  logic [31:0] b_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt;

  // Decode condition, compute outcome, target and mispredict.
  always_comb begin
    eval   = bus.valid_ex & ~bus.PL_stall & ~flush_q;
    b_eval = eval & bus.B_type_ex;
    j_eval = eval & bus.jalr_pred_ex & ~bus.B_type_ex;
    eq     = bus.rs1_data_ex == bus.rs2_data_ex;
    lt     = $signed(bus.rs1_data_ex) < $signed(bus.rs2_data_ex);
    ltu    = bus.rs1_data_ex < bus.rs2_data_ex;
    cond   = 6'b0;
    case (bus.func3_ex)
      3'b000:  cond = 6'b000001;
      3'b001:  cond = 6'b000010;
      3'b100:  cond = 6'b000100;
      3'b101:  cond = 6'b001000;
      3'b110:  cond = 6'b010000;
      3'b111:  cond = 6'b100000;
      default: cond = 6'b000000;
    endcase
    taken = 1'b0;
    unique case (1'b1)
      cond[0]: taken = eq;
      cond[1]: taken = ~eq;
      cond[2]: taken = lt;
      cond[3]: taken = ~lt;
      cond[4]: taken = ltu;
      cond[5]: taken = ~ltu;
      default: taken = 1'b0;
    endcase
    b_tgt  = taken ? bus.pc_ex + bus.imme_ex : bus.pc_ex + 32'd4;
    j_tgt  = (bus.rs1_data_ex + bus.imme_ex) & 32'hffff_fffe;
    b_miss = b_eval & (|cond)
           & (taken != bus.B_type_prediction_result_ex);
    j_miss = j_eval & (j_tgt != bus.jalr_pc_prediction_ex);
    miss   = b_miss | j_miss;
    tgt    = b_eval ? b_tgt : j_tgt;
  end

  // Flush, feedback and saturating statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      rollback_q <= 32'd0;
      filled_q   <= 32'd0;
      bfail_q    <= 1'b0;
      fail_q     <= 6'd0;
      pred_q     <= 1'b0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
    end else begin
      flush_q <= miss;
      bfail_q <= b_miss;
      fail_q  <= cond & {6{b_miss}};
      pred_q  <= b_miss & bus.B_type_prediction_result_ex;
      if (miss) begin
        rollback_q <= tgt;
        filled_q   <= bus.pc_ex;
      end
      if ((b_eval | j_eval) && bcnt_q != '1)
        bcnt_q <= bcnt_q + ONE;
      if (miss && mcnt_q != '1)
        mcnt_q <= mcnt_q + ONE;
    end
  end

  assign bus.PL_flush             = flush_q;
  assign bus.pc_rollback          = rollback_q;
  assign bus.pc_branch_filled     = filled_q;
  assign bus.B_type_branch_failed = bfail_q;
  assign bus.beq_branch_failed    = fail_q[0];
  assign bus.bne_branch_failed    = fail_q[1];
  assign bus.blt_branch_failed    = fail_q[2];
  assign bus.bge_branch_failed    = fail_q[3];
  assign bus.bltu_branch_failed   = fail_q[4];
  assign bus.bgeu_branch_failed   = fail_q[5];
  assign bus.branch_cnt           = bcnt_q;
  assign bus.miss_cnt             = mcnt_q;
  assign bus.B_type_prediction_result_branch_failed = pred_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random checks of branch_resolve
// against an outcome-level reference model.
module tb_branch_resolve;

  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_WIDTH(CW)) bus ();

  branch_resolve #(.CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic        m_flush;
  logic [31:0] m_rb;
  logic [31:0] m_pbf;
  logic        m_bfail;
  logic [5:0]  m_fail;
  logic        m_pred;
  int          m_bcnt;
  int          m_mcnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] onehot(logic [2:0] f3);
    case (f3)
      3'd0: return 6'd1;
      3'd1: return 6'd2;
      3'd4: return 6'd4;
      3'd5: return 6'd8;
      3'd6: return 6'd16;
      3'd7: return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

  task automatic model_step();
    logic ev, tk, ok, ms;
    logic [31:0] a, b, tg;
    if (rst) begin
      m_flush = 0; m_rb = 0; m_pbf = 0; m_bfail = 0;
      m_fail = 0; m_pred = 0; m_bcnt = 0; m_mcnt = 0;
      return;
    end
    a  = bus.rs1_data_ex;
    b  = bus.rs2_data_ex;
    ev = bus.valid_ex && !bus.PL_stall && !m_flush;
    ms = 0; tk = 0; ok = 1; tg = 0;
    if (ev && bus.B_type_ex) begin
      case (bus.func3_ex)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) < $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a < b);
        3'd7: tk = (a >= b);
        default: ok = 0;
      endcase
      ms = ok && (tk != bus.B_type_prediction_result_ex);
      tg = tk ? bus.pc_ex + bus.imme_ex : bus.pc_ex + 4;
    end else if (ev && bus.jalr_pred_ex) begin
      tg = (a + bus.imme_ex) & ~32'd1;
      ms = (tg != bus.jalr_pc_prediction_ex);
    end
    m_flush = ms;
    m_bfail = ms && bus.B_type_ex;
    m_fail  = m_bfail ? onehot(bus.func3_ex) : 6'd0;
    m_pred  = m_bfail && bus.B_type_prediction_result_ex;
    if (ms) begin
      m_rb  = tg;
      m_pbf = bus.pc_ex;
    end
    if (ev && (bus.B_type_ex || bus.jalr_pred_ex) && m_bcnt < MAXC)
      m_bcnt++;
    if (ms && m_mcnt < MAXC)
      m_mcnt++;
  endtask

  task automatic check_all();
    chk("flush", bus.PL_flush, m_flush);
    chk("rollback", bus.pc_rollback, m_rb);
    chk("filled", bus.pc_branch_filled, m_pbf);
    chk("bfail", bus.B_type_branch_failed, m_bfail);
    chk("onehot", {bus.bgeu_branch_failed, bus.bltu_branch_failed,
                   bus.bge_branch_failed, bus.blt_branch_failed,
                   bus.bne_branch_failed, bus.beq_branch_failed},
        m_fail);
    chk("predfail", bus.B_type_prediction_result_branch_failed, m_pred);
    chk("bcnt", bus.branch_cnt, m_bcnt);
    chk("mcnt", bus.miss_cnt, m_mcnt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.valid_ex = 0; bus.PL_stall = 0; bus.B_type_ex = 0;
    bus.jalr_pred_ex = 0; bus.func3_ex = 0; bus.pc_ex = 0;
    bus.imme_ex = 0; bus.rs1_data_ex = 0; bus.rs2_data_ex = 0;
    bus.B_type_prediction_result_ex = 0;
    bus.jalr_pc_prediction_ex = 0;
  endtask

  task automatic set_b(logic [31:0] pc, logic [31:0] imm,
                       logic [31:0] a, logic [31:0] b,
                       logic [2:0] f3, logic pred);
    idle();
    bus.valid_ex = 1; bus.B_type_ex = 1; bus.func3_ex = f3;
    bus.pc_ex = pc; bus.imme_ex = imm;
    bus.rs1_data_ex = a; bus.rs2_data_ex = b;
    bus.B_type_prediction_result_ex = pred;
  endtask

  task automatic set_j(logic [31:0] pc, logic [31:0] imm,
                       logic [31:0] a, logic [31:0] jp);
    idle();
    bus.valid_ex = 1; bus.jalr_pred_ex = 1;
    bus.pc_ex = pc; bus.imme_ex = imm;
    bus.rs1_data_ex = a; bus.jalr_pc_prediction_ex = jp;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    logic [31:0] a, b, imm;
    idle();
    rst = 1;
    m_flush = 0;
    // reset then idle
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    chk("idle_flush", bus.PL_flush, 0);
    chk("idle_rb", bus.pc_rollback, 0);

    // beq mispredict
    set_b(32'h100, 32'h40, 5, 5, 3'b000, 0);
    tick();
    chk("beq_flush", bus.PL_flush, 1);
    chk("beq_rb", bus.pc_rollback, 32'h140);
    chk("beq_bit", bus.beq_branch_failed, 1);
    chk("beq_pbf", bus.pc_branch_filled, 32'h100);
    chk("beq_pred", bus.B_type_prediction_result_branch_failed, 0);
    chk("beq_mcnt", bus.miss_cnt, 1);
    idle();
    tick();
    chk("beq_drop", bus.PL_flush, 0);

    // bltu correct, blt miss
    do_reset();
    set_b(32'h200, 32'h20, 32'hffffffff, 1, 3'b110, 0);
    tick();
    chk("bltu_flush", bus.PL_flush, 0);
    chk("bltu_bcnt", bus.branch_cnt, 1);
    set_b(32'h200, 32'h20, 32'hffffffff, 1, 3'b100, 0);
    tick();
    chk("blt_flush", bus.PL_flush, 1);
    chk("blt_rb", bus.pc_rollback, 32'h220);
    chk("blt_bit", bus.blt_branch_failed, 1);
    idle();
    tick();

    // jalr: target (0x203+0)&~1 = 0x202
    set_j(32'h300, 0, 32'h203, 32'h202);
    tick();
    chk("jalr_ok", bus.PL_flush, 0);
    set_j(32'h300, 0, 32'h203, 32'h204);
    tick();
    chk("jalr_flush", bus.PL_flush, 1);
    chk("jalr_rb", bus.pc_rollback, 32'h202);
    chk("jalr_bfail", bus.B_type_branch_failed, 0);
    idle();
    tick();

    // shadow cycle blocks a second mispredict
    do_reset();
    set_b(32'h400, 32'h10, 1, 2, 3'b000, 1);
    tick();
    tick();
    chk("shadow_flush", bus.PL_flush, 0);
    chk("shadow_mcnt", bus.miss_cnt, 1);
    idle();
    tick();

    // stall holds a mispredict until it drops
    do_reset();
    set_b(32'h500, 32'h10, 3, 3, 3'b001, 1);
    bus.PL_stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", bus.PL_flush, 0);
    end
    bus.PL_stall = 0;
    tick();
    chk("stall_flush", bus.PL_flush, 1);
    idle();
    tick();
    chk("stall_once", bus.PL_flush, 0);
    chk("stall_mcnt", bus.miss_cnt, 1);

    // saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_b(32'h600, 32'h8, 7, 7, 3'b000, 0);
      tick();
      idle();
      tick();
    end
    chk("sat_bcnt", bus.branch_cnt, 15);
    chk("sat_mcnt", bus.miss_cnt, 15);

    // reset mid-flush
    set_b(32'h700, 32'h8, 7, 7, 3'b000, 0);
    tick();
    chk("midrst_pre", bus.PL_flush, 1);
    idle();
    rst = 1;
    tick();
    chk("midrst_flush", bus.PL_flush, 0);
    rst = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.valid_ex = ($urandom_range(0, 9) < 8);
      bus.PL_stall = ($urandom_range(0, 4) == 0);
      bus.B_type_ex = $urandom_range(0, 1);
      bus.jalr_pred_ex = $urandom_range(0, 1);
      bus.func3_ex = 3'($urandom_range(0, 7));
      bus.pc_ex = $urandom & ~32'd3;
      imm = ($urandom_range(0, 1) != 0) ? $urandom
            : 32'($signed(8'($urandom)));
      bus.imme_ex = imm;
      a = ($urandom_range(0, 1) != 0) ? $urandom
          : 32'($urandom_range(0, 3)) - 2;
      b = ($urandom_range(0, 2) == 0) ? a
          : (($urandom_range(0, 1) != 0) ? $urandom
             : 32'($urandom_range(0, 3)) - 2);
      bus.rs1_data_ex = a;
      bus.rs2_data_ex = b;
      bus.B_type_prediction_result_ex = $urandom_range(0, 1);
      bus.jalr_pc_prediction_ex =
        ($urandom_range(0, 1) != 0) ? ((a + imm) & ~32'd1) : $urandom;
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
